path_readout_controller: RTL and testbench

// - Downstream partner of the SP/EP point-writer. Once the points are written and CPU

---
 rtl/path_readout_controller.sv | 176 +++++++++++++++++
 tb/tb_path_readout_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_readout_controller.sv
// Polls the CPU status word, then reads the finished path back node by node onto a valid/ready
// stream. Optional `PATH_CHECK_EN adds SP/EP ports and end-point checking of the path.
module path_readout_controller #(
  parameter logic [31:0] STATUS_ADR  = 32'h0200_0008,
  parameter logic [31:0] PATH_BASE   = 32'h0200_0010,
  parameter int unsigned MAX_NODES   = 32,
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] Ext_ReadData,
`ifdef PATH_CHECK_EN
  input  logic [4:0]  SP,
  input  logic [4:0]  EP,
`endif
  output logic [31:0] Ext_DataAdr,
  output logic        Ext_MemWrite,
  output logic        bus_req,
  output logic [4:0]  node,
  output logic        node_valid,
  input  logic        node_ready,
  output logic [5:0]  path_len,
  output logic        path_done,
  output logic        path_err
);

  localparam int unsigned TmoW = ($clog2(TIMEOUT_CYC + 1) > 20) ? $clog2(TIMEOUT_CYC + 1) : 20;
  localparam int unsigned GapW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StPollAdr  = 4'd1;
  localparam logic [3:0] StPollWait = 4'd2;
  localparam logic [3:0] StGap      = 4'd3;
  localparam logic [3:0] StReadAdr  = 4'd4;
  localparam logic [3:0] StReadWait = 4'd5;
  localparam logic [3:0] StOutput   = 4'd6;
  localparam logic [3:0] StDone     = 4'd7;
  localparam logic [3:0] StErr      = 4'd8;

  logic [3:0]      state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [5:0]      idx_q, idx_d;
  logic [5:0]      path_len_q, path_len_d;
  logic [4:0]      node_q, node_d;
  logic            node_valid_q, node_valid_d;
  logic            chk_fail_q, chk_fail_d;
  logic            tmo_hit;
  logic            last_node;

  assign tmo_hit   = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
  assign last_node = ((idx_q + 6'd1) == path_len_q);

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    idx_d        = idx_q;
    path_len_d   = path_len_q;
    node_d       = node_q;
    node_valid_d = node_valid_q;
    chk_fail_d   = chk_fail_q;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StPollAdr;
          tmo_d      = '0;
          gap_d      = '0;
          idx_d      = '0;
          path_len_d = '0;
          chk_fail_d = 1'b0;
        end
      end
      StPollAdr: begin
        tmo_d   = tmo_q + TmoW'(1);
        state_d = tmo_hit ? StErr : StPollWait;
      end
      StPollWait: begin
        tmo_d = tmo_q + TmoW'(1);
        // Timeout wins over a status word arriving in the same cycle.
        if (tmo_hit) begin
          state_d = StErr;
        end else if (Ext_ReadData == 32'd0) begin
          state_d = StGap;
          gap_d   = '0;
        end else if (Ext_ReadData <= 32'(MAX_NODES)) begin
          path_len_d = Ext_ReadData[5:0];
          state_d    = StReadAdr;
        end else begin
          state_d = StErr;
        end
      end
      StGap: begin
        tmo_d = tmo_q + TmoW'(1);
        if (tmo_hit) begin
          state_d = StErr;
        end else if (gap_q == GapW'(POLL_GAP - 1)) begin
          state_d = StPollAdr;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StReadAdr: begin
        state_d = StReadWait;
      end
      StReadWait: begin
        node_d       = Ext_ReadData[4:0];
        node_valid_d = 1'b1;
        state_d      = StOutput;
`ifdef PATH_CHECK_EN
        if ((idx_q == 6'd0 && Ext_ReadData[4:0] != SP) ||
            (last_node && Ext_ReadData[4:0] != EP)) begin
          chk_fail_d = 1'b1;
        end
`endif
      end
      StOutput: begin
        if (node_ready) begin
          node_valid_d = 1'b0;
          idx_d        = idx_q + 6'd1;
          if (last_node) begin
            state_d = chk_fail_q ? StErr : StDone;
          end else begin
            state_d = StReadAdr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      tmo_q        <= '0;
      gap_q        <= '0;
      idx_q        <= '0;
      path_len_q   <= '0;
      node_q       <= '0;
      node_valid_q <= 1'b0;
      chk_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      idx_q        <= idx_d;
      path_len_q   <= path_len_d;
      node_q       <= node_d;
      node_valid_q <= node_valid_d;
      chk_fail_q   <= chk_fail_d;
    end
  end

  always_comb begin
    Ext_DataAdr = 32'd0;
    bus_req     = 1'b0;
    if (state_q == StPollAdr) begin
      Ext_DataAdr = STATUS_ADR;
      bus_req     = 1'b1;
    end else if (state_q == StReadAdr) begin
      Ext_DataAdr = PATH_BASE + {24'd0, idx_q, 2'b00};
      bus_req     = 1'b1;
    end
  end

  assign Ext_MemWrite = 1'b0;
  assign node         = node_q;
  assign node_valid   = node_valid_q;
  assign path_len     = path_len_q;
  assign path_done    = (state_q == StDone);
  assign path_err     = (state_q == StErr);

endmodule

// File: tb/tb_path_readout_controller.sv
// Directed bench for path_readout_controller with a small registered memory model.
module tb_path_readout_controller;

  localparam logic [31:0] STATUS_ADR = 32'h0200_0008;
  localparam logic [31:0] PATH_BASE  = 32'h0200_0010;
  localparam int TO = 200;
  localparam int PG = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] rdata;
  logic [4:0]  SP = '0;
  logic [4:0]  EP = '0;
  logic [31:0] Ext_DataAdr;
  logic        Ext_MemWrite;
  logic        bus_req;
  logic [4:0]  node;
  logic        node_valid;
  logic        node_ready = 1'b0;
  logic [5:0]  path_len;
  logic        path_done;
  logic        path_err;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int poll_cnt = 0;
  int zero_limit = 0;
  logic [31:0] status_val = 32'd0;
  logic [4:0] node_mem [32];
  int poll_times[$];
  int got[$];
  int got_t[$];
  bit seen_valid;

  always #5 clk = ~clk;

  path_readout_controller #(
    .STATUS_ADR (STATUS_ADR),
    .PATH_BASE  (PATH_BASE),
    .MAX_NODES  (32),
    .POLL_GAP   (PG),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .Ext_ReadData(rdata),
`ifdef PATH_CHECK_EN
    .SP          (SP),
    .EP          (EP),
`endif
    .Ext_DataAdr (Ext_DataAdr),
    .Ext_MemWrite(Ext_MemWrite),
    .bus_req     (bus_req),
    .node        (node),
    .node_valid  (node_valid),
    .node_ready  (node_ready),
    .path_len    (path_len),
    .path_done   (path_done),
    .path_err    (path_err)
  );

  // Memory answers one cycle after the address; idle cycles return junk.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_req && Ext_DataAdr == STATUS_ADR) begin
      poll_times.push_back(cyc);
      rdata <= (poll_cnt < zero_limit) ? 32'd0 : status_val;
      poll_cnt <= poll_cnt + 1;
    end else if (bus_req) begin
      rdata <= {27'd0, node_mem[5'((Ext_DataAdr - PATH_BASE) >> 2)]};
    end else begin
      rdata <= 32'hFFFF_FFFF;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_end(input int max_cyc, output bit fin);
    fin = 1'b0;
    got.delete();
    got_t.delete();
    seen_valid = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (node_valid) seen_valid = 1'b1;
      if (node_valid && node_ready) begin
        got.push_back(int'(node));
        got_t.push_back(cyc);
      end
      if (path_done || path_err) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (node_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++; if ({node_valid, path_done, path_err, bus_req, Ext_MemWrite} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {node_valid, path_done, path_err, bus_req, Ext_MemWrite}); else n_pass++;
    n_total++; if (Ext_DataAdr !== 32'd0)
      $display("FAIL reset_adr: got %h want 0", Ext_DataAdr); else n_pass++;
    n_total++; if ({path_len, node} !== 11'd0)
      $display("FAIL reset_len_node: got %0d/%0d want 0/0", path_len, node); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (bus_req !== 1'b0)
      $display("FAIL idle_no_bus: got %b want 0", bus_req); else n_pass++;
  endtask

  task automatic test_basic();
    int base;
    bit fin;
    base = poll_times.size();
    zero_limit = poll_cnt + 3;
    status_val = 32'd3;
    node_mem[0] = 5'd4; node_mem[1] = 5'd9; node_mem[2] = 5'd12;
    SP = 5'd4; EP = 5'd12;
    node_ready = 1'b1;
    pulse_start();
    n_total++; if (Ext_DataAdr !== STATUS_ADR || bus_req !== 1'b1)
      $display("FAIL basic_first_poll: got %h/%b want %h/1", Ext_DataAdr, bus_req, STATUS_ADR);
    else n_pass++;
    // Stray start while polling must be ignored.
    repeat (2) @(negedge clk);
    pulse_start();
    run_to_end(300, fin);
    n_total++; if (fin !== 1'b1) $display("FAIL basic_end: got %b want 1", fin); else n_pass++;
    n_total++; if (poll_times.size() - base != 4)
      $display("FAIL basic_polls: got %0d want 4", poll_times.size() - base); else n_pass++;
    for (int i = 1; i < 4 && base + i < poll_times.size(); i++) begin
      n_total++; if (poll_times[base + i] - poll_times[base + i - 1] != PG + 2)
        $display("FAIL basic_poll_gap: got %0d want %0d",
                 poll_times[base + i] - poll_times[base + i - 1], PG + 2); else n_pass++;
    end
    n_total++; if (got.size() != 3 || got[0] != 4 || got[1] != 9 || got[2] != 12)
      $display("FAIL basic_nodes: got %p want 4 9 12", got); else n_pass++;
    n_total++; if (got_t.size() == 3 && (got_t[1] - got_t[0] != 3 || got_t[2] - got_t[1] != 3))
      $display("FAIL basic_rate: got %p want spacing 3", got_t); else n_pass++;
    n_total++; if (path_len !== 6'd3) $display("FAIL basic_len: got %0d want 3", path_len);
    else n_pass++;
    n_total++; if ({path_done, path_err, bus_req} !== 3'b100)
      $display("FAIL basic_flags: got %b want 100", {path_done, path_err, bus_req}); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit found;
    bit fin;
    zero_limit = poll_cnt;
    status_val = 32'd2;
    node_mem[0] = 5'd7; node_mem[1] = 5'd1;
    SP = 5'd7; EP = 5'd1;
    node_ready = 1'b0;
    pulse_start();
    n_total++; if (path_done !== 1'b0) $display("FAIL bp_restart: got %b want 0", path_done);
    else n_pass++;
    wait_valid(50, found);
    n_total++; if (found !== 1'b1) $display("FAIL bp_valid: got %b want 1", found); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_total++; if (node !== 5'd7 || node_valid !== 1'b1)
        $display("FAIL bp_hold: got %0d/%b want 7/1", node, node_valid); else n_pass++;
      n_total++; if (Ext_DataAdr !== 32'd0 || bus_req !== 1'b0)
        $display("FAIL bp_bus: got %h/%b want 0/0", Ext_DataAdr, bus_req); else n_pass++;
      @(negedge clk);
    end
    node_ready = 1'b1;
    run_to_end(100, fin);
    n_total++; if (fin !== 1'b1 || got.size() != 2 || got[0] != 7 || got[1] != 1)
      $display("FAIL bp_nodes: got %p want 7 1", got); else n_pass++;
    n_total++; if (path_len !== 6'd2 || path_done !== 1'b1)
      $display("FAIL bp_done: got %0d/%b want 2/1", path_len, path_done); else n_pass++;
  endtask

  task automatic test_bad_len();
    bit fin;
    zero_limit = poll_cnt;
    status_val = 32'd33;
    pulse_start();
    run_to_end(100, fin);
    n_total++; if (fin !== 1'b1) $display("FAIL bad_end: got %b want 1", fin); else n_pass++;
    n_total++; if ({path_err, path_done, bus_req, seen_valid} !== 4'b1000)
      $display("FAIL bad_flags: got %b want 1000", {path_err, path_done, bus_req, seen_valid});
    else n_pass++;
    n_total++; if (path_len !== 6'd0) $display("FAIL bad_len: got %0d want 0", path_len);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit early;
    early = 1'b0;
    zero_limit = poll_cnt + 1000;
    pulse_start();
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      if (path_err) early = 1'b1;
    end
    n_total++; if (early !== 1'b0) $display("FAIL tmo_early: got %b want 0", early); else n_pass++;
    @(negedge clk);
    n_total++; if ({path_err, path_done, bus_req} !== 3'b100)
      $display("FAIL tmo_hit: got %b want 100", {path_err, path_done, bus_req}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found;
    bit fin;
    zero_limit = poll_cnt;
    status_val = 32'd3;
    node_mem[0] = 5'd4; node_mem[1] = 5'd9; node_mem[2] = 5'd12;
    SP = 5'd4; EP = 5'd12;
    node_ready = 1'b0;
    pulse_start();
    wait_valid(50, found);
    n_total++; if (found !== 1'b1 || path_len !== 6'd3)
      $display("FAIL rm_output: got %b/%0d want 1/3", found, path_len); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if ({node_valid, bus_req, path_err, path_done} !== 4'b0 || path_len !== 6'd0)
      $display("FAIL rm_async: got %b/%0d want 0000/0",
               {node_valid, bus_req, path_err, path_done}, path_len); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (bus_req !== 1'b0 || node_valid !== 1'b0)
      $display("FAIL rm_idle: got %b/%b want 0/0", bus_req, node_valid); else n_pass++;
    node_ready = 1'b1;
    pulse_start();
    n_total++; if (Ext_DataAdr !== STATUS_ADR || bus_req !== 1'b1)
      $display("FAIL rm_repoll: got %h/%b want %h/1", Ext_DataAdr, bus_req, STATUS_ADR);
    else n_pass++;
    run_to_end(100, fin);
    n_total++; if (fin !== 1'b1 || got.size() != 3 || got[0] != 4 || got[2] != 12 || !path_done)
      $display("FAIL rm_rerun: got %p done=%b want 4 9 12 done=1", got, path_done); else n_pass++;
  endtask

`ifdef PATH_CHECK_EN
  task automatic test_path_check();
    bit fin;
    zero_limit = poll_cnt;
    status_val = 32'd3;
    node_mem[0] = 5'd2; node_mem[1] = 5'd3; node_mem[2] = 5'd6;
    SP = 5'd2; EP = 5'd5;
    node_ready = 1'b1;
    pulse_start();
    run_to_end(100, fin);
    n_total++; if (fin !== 1'b1 || got.size() != 3 || got[0] != 2 || got[1] != 3 || got[2] != 6)
      $display("FAIL chk_nodes: got %p want 2 3 6", got); else n_pass++;
    n_total++; if ({path_err, path_done} !== 2'b10)
      $display("FAIL chk_err: got %b want 10", {path_err, path_done}); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bad_len();
    test_timeout();
    test_reset_mid();
`ifdef PATH_CHECK_EN
    test_path_check();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
